// File: rtl/led_sweep_engine.sv
// led_sweep_engine: sweeps a write head across an LED bar, lighting
// (fill) or extinguishing (dim) up to three LEDs per tick. Sweep modes:
// modulo wrap or ping-pong bounce. A sweep completes when every LED holds
// the target value. The block then optionally restarts.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               load/restart (beats tick and pause)
//   init_pos, step,     latched at start; step 0 acts as 1,
//   fill_mode,          init_pos is clamped to NUM_LEDS-1
//   bounce_mode
//   loop_en, rate_sel   live controls (repeat, tick rate 2^rate_sel/CLK_HZ)
//   pause               freezes tick counter and sweep
//   led, position       LED drive and current head index
//   busy                not IDLE
//   cycle_done          one-clk pulse when a sweep completes
//   cycle_count         completed sweeps, mod 256
module led_sweep_engine #(
  parameter int NUM_LEDS = 16,
  parameter int CLK_HZ   = 100_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(NUM_LEDS)-1:0] init_pos,
  input  logic [1:0]                  step,
  input  logic                        fill_mode,
  input  logic                        bounce_mode,
  input  logic                        loop_en,
  input  logic [1:0]                  rate_sel,
  input  logic                        pause,
  output logic [NUM_LEDS-1:0]         led,
  output logic [$clog2(NUM_LEDS)-1:0] position,
  output logic                        busy,
  output logic                        cycle_done,
  output logic [7:0]                  cycle_count
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam logic [PW+1:0]       N_W  = (PW+2)'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pos_q, pos_d, init_q, init_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                dn_q, dn_d, fill_q, fill_d, bnc_q, bnc_d, done_q, done_d;
  logic [1:0]          step_q, step_d;
  logic [7:0]          cnt8_q, cnt8_d;
  logic [31:0]         tcnt_q, tcnt_d, period;
  logic                tick;

  logic [NUM_LEDS-1:0] wmask, led_w;
  logic [PW+1:0]       pos_w, step_w, sum, idx;

  // Live rate_sel; the >= compare keeps a counter that was already past a
  // newly shortened period from running away.
  always_comb begin
    period = 32'(CLK_HZ) >> rate_sel;
    if (period == 32'd0) period = 32'd1;
    tick = (tcnt_q >= period - 32'd1);
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    init_d  = init_q;
    led_d   = led_q;
    dn_d    = dn_q;
    fill_d  = fill_q;
    bnc_d   = bnc_q;
    step_d  = step_q;
    cnt8_d  = cnt8_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    wmask   = '0;
    idx     = '0;
    pos_w   = {2'b00, pos_q};
    step_w  = (PW+2)'(step_q);
    sum     = pos_w + step_w;

    // Mask of LEDs the head covers this tick; bounce drops out-of-range ones.
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < step_q) begin
        if (!bnc_q) begin
          idx = pos_w + (PW+2)'(k);
          if (idx >= N_W) idx = idx - N_W;
          wmask = wmask | (ONE << idx);
        end else if (!dn_q) begin
          idx = pos_w + (PW+2)'(k);
          if (idx < N_W) wmask = wmask | (ONE << idx);
        end else if (pos_w >= (PW+2)'(k)) begin
          idx = pos_w - (PW+2)'(k);
          wmask = wmask | (ONE << idx);
        end
      end
    end
    led_w = fill_q ? (led_q | wmask) : (led_q & ~wmask);

    if (start) begin
      state_d = S_RUN;
      init_d  = ({2'b00, init_pos} >= N_W) ? PW'(NUM_LEDS - 1) : init_pos;
      pos_d   = ({2'b00, init_pos} >= N_W) ? PW'(NUM_LEDS - 1) : init_pos;
      led_d   = fill_mode ? '0 : '1;
      fill_d  = fill_mode;
      bnc_d   = bounce_mode;
      step_d  = (step == 2'd0) ? 2'd1 : step;
      dn_d    = 1'b0;
      tcnt_d  = '0;
    end else if (!pause) begin
      tcnt_d = tick ? '0 : tcnt_q + 32'd1;
      if (tick) begin
        case (state_q)
          S_RUN: begin
            led_d = led_w;
            if (!bnc_q) begin
              pos_d = PW'((sum >= N_W) ? sum - N_W : sum);
            end else if (!dn_q) begin
              if (sum <= N_W - 1) pos_d = PW'(sum);
              else begin
                pos_d = PW'(NUM_LEDS - 1);
                dn_d  = 1'b1;
              end
            end else begin
              if (pos_w >= step_w) pos_d = PW'(pos_w - step_w);
              else begin
                pos_d = '0;
                dn_d  = 1'b0;
              end
            end
            if (fill_q ? (&led_w) : ~(|led_w)) begin
              done_d  = 1'b1;
              cnt8_d  = cnt8_q + 8'd1;
              state_d = S_FULL;
            end
          end
          S_FULL: begin
            if (loop_en) begin
              led_d   = fill_q ? '0 : '1;
              pos_d   = init_q;
              dn_d    = 1'b0;
              state_d = S_RUN;
            end else begin
              state_d = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      init_q  <= '0;
      led_q   <= '0;
      dn_q    <= 1'b0;
      fill_q  <= 1'b0;
      bnc_q   <= 1'b0;
      step_q  <= 2'd1;
      cnt8_q  <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      init_q  <= init_d;
      led_q   <= led_d;
      dn_q    <= dn_d;
      fill_q  <= fill_d;
      bnc_q   <= bnc_d;
      step_q  <= step_d;
      cnt8_q  <= cnt8_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
    end
  end

  assign led         = led_q;
  assign position    = pos_q;
  assign busy        = (state_q != S_IDLE);
  assign cycle_done  = done_q;
  assign cycle_count = cnt8_q;
endmodule

// File: tb/tb_led_sweep_engine.sv
module tb_led_sweep_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  init_pos = '0;
  logic [1:0]  step = '0;
  logic        fill_mode = 1'b0, bounce_mode = 1'b0, loop_en = 1'b0;
  logic [1:0]  rate_sel = '0;
  logic        pause = 1'b0;
  logic [15:0] led;
  logic [3:0]  position;
  logic        busy, cycle_done;
  logic [7:0]  cycle_count;

  int checks = 0;
  int failures = 0;

  led_sweep_engine #(.NUM_LEDS(16), .CLK_HZ(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_pos(init_pos),
    .step(step), .fill_mode(fill_mode), .bounce_mode(bounce_mode),
    .loop_en(loop_en), .rate_sel(rate_sel), .pause(pause), .led(led),
    .position(position), .busy(busy), .cycle_done(cycle_done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  step;
    logic        fill, bounce, loop_en;
    logic [3:0]  init;
    int          nt;
    logic [15:0] led;
    logic [3:0]  pos;
    logic        busy, done;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Assumes caller is at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input logic [1:0] s, input logic f, input logic b,
                          input logic l, input logic [3:0] ip);
    step = s; fill_mode = f; bounce_mode = b; loop_en = l; init_pos = ip;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // With CLK_HZ=8 and rate_sel=0, one tick is 8 clocks.
  task automatic wait_ticks(input int n);
    repeat (8 * n) @(negedge clk);
  endtask

  initial begin
    //        step fill bnc loop init nt  led       pos  busy done cnt
    vt[0]  = '{2'd1, 1, 0, 1, 4'd14,  1, 16'h4000, 4'd15, 1, 0, 8'd0};
    vt[1]  = '{2'd1, 1, 0, 1, 4'd14,  3, 16'hC001, 4'd1,  1, 0, 8'd0};
    vt[2]  = '{2'd1, 1, 0, 1, 4'd14, 16, 16'hFFFF, 4'd14, 1, 1, 8'd1};
    vt[3]  = '{2'd1, 1, 0, 1, 4'd14, 17, 16'h0000, 4'd14, 1, 0, 8'd1};
    vt[4]  = '{2'd2, 0, 0, 1, 4'd0,   8, 16'h0000, 4'd0,  1, 1, 8'd1};
    vt[5]  = '{2'd2, 0, 0, 0, 4'd0,   9, 16'h0000, 4'd0,  0, 0, 8'd1};
    vt[6]  = '{2'd3, 1, 1, 1, 4'd12,  1, 16'h7000, 4'd15, 1, 0, 8'd0};
    vt[7]  = '{2'd3, 1, 1, 1, 4'd12,  2, 16'hF000, 4'd15, 1, 0, 8'd0};
    vt[8]  = '{2'd3, 1, 1, 1, 4'd12,  3, 16'hF000, 4'd12, 1, 0, 8'd0};
    vt[9]  = '{2'd0, 1, 0, 1, 4'd3,   2, 16'h0018, 4'd5,  1, 0, 8'd0};
    vt[10] = '{2'd3, 1, 1, 1, 4'd12,  8, 16'hFFFF, 4'd0,  1, 1, 8'd1};

    // Power-on reset values
    #3;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_pos", 32'(position), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(cycle_count), 32'h0);
    chk("rst_done", 32'(cycle_done), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_reset();
      do_start(vt[i].step, vt[i].fill, vt[i].bounce, vt[i].loop_en, vt[i].init);
      wait_ticks(vt[i].nt);
      chk($sformatf("v%0d_led", i),  32'(led),         32'(vt[i].led));
      chk($sformatf("v%0d_pos", i),  32'(position),    32'(vt[i].pos));
      chk($sformatf("v%0d_busy", i), 32'(busy),        32'(vt[i].busy));
      chk($sformatf("v%0d_done", i), 32'(cycle_done),  32'(vt[i].done));
      chk($sformatf("v%0d_cnt", i),  32'(cycle_count), 32'(vt[i].cnt));
    end

    // Pause mid-tick: state and tick phase must freeze.
    do_reset();
    do_start(2'd1, 1'b1, 1'b0, 1'b1, 4'd0);
    wait_ticks(1);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (40) @(negedge clk);
    chk("pause_led", 32'(led), 32'h0001);
    chk("pause_pos", 32'(position), 32'd1);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    chk("resume_early_led", 32'(led), 32'h0001);
    @(negedge clk);
    chk("resume_led", 32'(led), 32'h0003);
    chk("resume_pos", 32'(position), 32'd2);

    // Start coincident with a tick: reload wins, no write, counter cleared.
    do_reset();
    do_start(2'd1, 1'b1, 1'b0, 1'b1, 4'd0);
    wait_ticks(1);
    chk("pre_led", 32'(led), 32'h0001);
    repeat (7) @(negedge clk);
    do_start(2'd1, 1'b1, 1'b0, 1'b1, 4'd5);
    chk("st_tick_led", 32'(led), 32'h0000);
    chk("st_tick_pos", 32'(position), 32'd5);
    repeat (7) @(negedge clk);
    chk("st_tick_wait_led", 32'(led), 32'h0000);
    @(negedge clk);
    chk("st_tick_first_led", 32'(led), 32'h0020);
    chk("st_tick_first_pos", 32'(position), 32'd6);

    // Asynchronous reset mid-sweep, away from any clock edge.
    wait_ticks(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_pos", 32'(position), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_cnt", 32'(cycle_count), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_led", 32'(led), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
